// File: rtl/spi_fifo.sv
// rtl/spi_fifo.sv - first-word-fall-through synchronous FIFO for the CoreSPI TX/RX paths
// Optional level output enabled by defining SPI_FIFO_LEVEL_EN.
module spi_fifo #(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 4
) (
    input  logic              pclk,
    input  logic              aresetn,
    input  logic              clr,
    input  logic              we,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    output logic [DWIDTH-1:0] rdata,
    output logic              full,
    output logic              full_next,
    output logic              empty,
    output logic              empty_next,
    output logic              overflow,
    output logic              underflow
`ifdef SPI_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] level
`endif
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_FULLN = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_full;
    logic              w_empty;
    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [AW-1:0]     w_wr_ptr_nxt;
    logic [AW-1:0]     w_rd_ptr_nxt;

    // Flags come straight from the registered count so they never glitch
    assign w_full   = (r_count == CNT_FULL);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = !clr && we && (!w_full || re);
    assign w_rd_acc = !clr && re && !w_empty;

    // Explicit wrap keeps non-power-of-two depths correct
    assign w_wr_ptr_nxt = (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + AW'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + AW'(1);

    always_ff @(posedge pclk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge pclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (clr) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_wr_acc && w_rd_acc) begin
                r_count <= r_count - CNT_ONE;
            end
            r_overflow  <= we && w_full && !re;
            r_underflow <= re && w_empty;
        end
    end

    assign rdata      = w_empty ? '0 : r_mem[r_rd_ptr];
    assign full       = w_full;
    assign full_next  = (r_count == CNT_FULLN);
    assign empty      = w_empty;
    assign empty_next = (r_count == CNT_ONE);
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

`ifdef SPI_FIFO_LEVEL_EN
    assign level = r_count;
`endif

endmodule

// File: tb/tb_spi_fifo.sv
// tb/tb_spi_fifo.sv - self-checking bench for spi_fifo (DEPTH=4 main instance, DEPTH=5 wrap instance)
module tb_spi_fifo;
    localparam int DEPTH = 4;

    logic       pclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       clr = 1'b0, we = 1'b0, re = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       full, full_next, empty, empty_next, overflow, underflow;

    logic       clr5 = 1'b0, we5 = 1'b0, re5 = 1'b0;
    logic [7:0] wdata5 = 8'h00;
    logic [7:0] rdata5;
    logic       full5, full_next5, empty5, empty_next5, overflow5, underflow5;
`ifdef SPI_FIFO_LEVEL_EN
    logic [2:0] level;
    logic [2:0] level5;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 pclk = ~pclk;

    spi_fifo #(.DWIDTH(8), .DEPTH(DEPTH)) dut (
        .pclk(pclk), .aresetn(aresetn), .clr(clr), .we(we), .wdata(wdata), .re(re),
        .rdata(rdata), .full(full), .full_next(full_next), .empty(empty),
        .empty_next(empty_next), .overflow(overflow), .underflow(underflow)
`ifdef SPI_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    spi_fifo #(.DWIDTH(8), .DEPTH(5)) dut5 (
        .pclk(pclk), .aresetn(aresetn), .clr(clr5), .we(we5), .wdata(wdata5), .re(re5),
        .rdata(rdata5), .full(full5), .full_next(full_next5), .empty(empty5),
        .empty_next(empty_next5), .overflow(overflow5), .underflow(underflow5)
`ifdef SPI_FIFO_LEVEL_EN
        , .level(level5)
`endif
    );

    // Reference model: a queue of words plus the two pulse flags
    logic [7:0] mq[$];
    bit         m_ov, m_un;

    typedef struct {
        bit         c, w, r;
        logic [7:0] d;
        logic [7:0] e_rdata;
        bit         e_full, e_fn, e_empty, e_en, e_ov, e_un;
        int         e_level;
    } vec_t;
    vec_t vecs[$];

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_edge(input bit c, input bit w, input bit r, input logic [7:0] d);
        bit was_full, was_empty;
        was_full  = (mq.size() == DEPTH);
        was_empty = (mq.size() == 0);
        if (c) begin
            mq.delete();
            m_ov = 0;
            m_un = 0;
        end else begin
            m_ov = w && was_full && !r;
            m_un = r && was_empty;
            if (r && !was_empty) void'(mq.pop_front());
            if (w && (!was_full || r)) mq.push_back(d);
        end
    endtask

    task automatic step(input bit c, input bit w, input bit r, input logic [7:0] d);
        clr = c; we = w; re = r; wdata = d;
        model_edge(c, w, r, d);
        @(posedge pclk);
        #1;
        clr = 0; we = 0; re = 0;
    endtask

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        cmp({tag, " rdata"}, 32'(rdata), (n != 0) ? 32'(mq[0]) : 32'h0);
        cmp({tag, " full"}, 32'(full), 32'(n == DEPTH));
        cmp({tag, " full_next"}, 32'(full_next), 32'(n == DEPTH - 1));
        cmp({tag, " empty"}, 32'(empty), 32'(n == 0));
        cmp({tag, " empty_next"}, 32'(empty_next), 32'(n == 1));
        cmp({tag, " overflow"}, 32'(overflow), 32'(m_ov));
        cmp({tag, " underflow"}, 32'(underflow), 32'(m_un));
`ifdef SPI_FIFO_LEVEL_EN
        cmp({tag, " level"}, 32'(level), 32'(n));
`endif
    endtask

    task automatic add(input bit c, w, r, input logic [7:0] d, input logic [7:0] er,
                       input bit ef, efn, ee, een, eov, eun, input int el);
        vec_t v;
        v.c = c; v.w = w; v.r = r; v.d = d; v.e_rdata = er;
        v.e_full = ef; v.e_fn = efn; v.e_empty = ee; v.e_en = een;
        v.e_ov = eov; v.e_un = eun; v.e_level = el;
        vecs.push_back(v);
    endtask

    initial begin
        logic [7:0] q5[$];
        logic [7:0] b;

        //  c w r  data   rdata  F FN E EN OV UN lvl
        add(0,1,0, 8'h11, 8'h11, 0,0,0,1,0,0, 1);
        add(0,1,0, 8'h22, 8'h11, 0,0,0,0,0,0, 2);
        add(0,1,0, 8'h33, 8'h11, 0,1,0,0,0,0, 3);
        add(0,1,0, 8'h44, 8'h11, 1,0,0,0,0,0, 4);
        add(0,1,0, 8'h55, 8'h11, 1,0,0,0,1,0, 4);
        add(0,0,0, 8'h00, 8'h11, 1,0,0,0,0,0, 4);
        add(0,0,1, 8'h00, 8'h22, 0,1,0,0,0,0, 3);
        add(0,0,1, 8'h00, 8'h33, 0,0,0,0,0,0, 2);
        add(0,0,1, 8'h00, 8'h44, 0,0,0,1,0,0, 1);
        add(0,0,1, 8'h00, 8'h00, 0,0,1,0,0,0, 0);
        add(0,0,1, 8'h00, 8'h00, 0,0,1,0,0,1, 0);
        add(0,0,0, 8'h00, 8'h00, 0,0,1,0,0,0, 0);
        add(0,1,0, 8'h11, 8'h11, 0,0,0,1,0,0, 1);
        add(0,1,0, 8'h22, 8'h11, 0,0,0,0,0,0, 2);
        add(0,1,0, 8'h33, 8'h11, 0,1,0,0,0,0, 3);
        add(0,1,0, 8'h44, 8'h11, 1,0,0,0,0,0, 4);
        add(0,1,1, 8'h66, 8'h22, 1,0,0,0,0,0, 4);
        add(0,0,1, 8'h00, 8'h33, 0,1,0,0,0,0, 3);
        add(0,0,1, 8'h00, 8'h44, 0,0,0,0,0,0, 2);
        add(0,0,1, 8'h00, 8'h66, 0,0,0,1,0,0, 1);
        add(0,0,1, 8'h00, 8'h00, 0,0,1,0,0,0, 0);
        add(0,1,1, 8'hA5, 8'hA5, 0,0,0,1,0,1, 1);
        add(0,0,0, 8'h00, 8'hA5, 0,0,0,1,0,0, 1);
        add(0,1,0, 8'hB6, 8'hA5, 0,0,0,0,0,0, 2);
        add(0,1,0, 8'hC7, 8'hA5, 0,1,0,0,0,0, 3);
        add(1,1,0, 8'hD8, 8'h00, 0,0,1,0,0,0, 0);
        add(1,0,1, 8'h00, 8'h00, 0,0,1,0,0,0, 0);

        // Reset state
        #2;
        cmp("reset empty", 32'(empty), 32'h1);
        cmp("reset full", 32'(full), 32'h0);
        cmp("reset full_next", 32'(full_next), 32'h0);
        cmp("reset empty_next", 32'(empty_next), 32'h0);
        cmp("reset rdata", 32'(rdata), 32'h0);
        cmp("reset overflow", 32'(overflow), 32'h0);
        cmp("reset underflow", 32'(underflow), 32'h0);
`ifdef SPI_FIFO_LEVEL_EN
        cmp("reset level", 32'(level), 32'h0);
`endif
        @(negedge pclk);
        aresetn = 1'b1;
        @(posedge pclk);
        #1;

        // Directed table
        foreach (vecs[i]) begin
            string t;
            t = $sformatf("vec%0d", i);
            step(vecs[i].c, vecs[i].w, vecs[i].r, vecs[i].d);
            cmp({t, " rdata"}, 32'(rdata), 32'(vecs[i].e_rdata));
            cmp({t, " full"}, 32'(full), 32'(vecs[i].e_full));
            cmp({t, " full_next"}, 32'(full_next), 32'(vecs[i].e_fn));
            cmp({t, " empty"}, 32'(empty), 32'(vecs[i].e_empty));
            cmp({t, " empty_next"}, 32'(empty_next), 32'(vecs[i].e_en));
            cmp({t, " overflow"}, 32'(overflow), 32'(vecs[i].e_ov));
            cmp({t, " underflow"}, 32'(underflow), 32'(vecs[i].e_un));
`ifdef SPI_FIFO_LEVEL_EN
            cmp({t, " level"}, 32'(level), 32'(vecs[i].e_level));
`endif
        end

        // Randomized traffic against the queue model
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        // Asynchronous reset in the middle of a cycle with content present
        step(0, 1, 0, 8'h5A);
        step(0, 1, 0, 8'h6B);
        #2;
        aresetn = 1'b0;
        #1;
        mq.delete();
        m_ov = 0;
        m_un = 0;
        check_model("async_rst");
        @(negedge pclk);
        aresetn = 1'b1;
        step(0, 0, 0, 8'h00);
        check_model("post_rst");

        // DEPTH=5 instance: preload 3, then 12 simultaneous write/read pairs across wrap
        for (int i = 0; i < 3; i++) begin
            b = 8'(8'h30 + i);
            we5 = 1; wdata5 = b; q5.push_back(b);
            @(posedge pclk);
            #1;
            we5 = 0;
        end
        for (int i = 0; i < 12; i++) begin
            cmp($sformatf("d5 pair%0d head", i), 32'(rdata5), 32'(q5[0]));
            b = 8'($urandom);
            we5 = 1; re5 = 1; wdata5 = b;
            void'(q5.pop_front());
            q5.push_back(b);
            @(posedge pclk);
            #1;
            we5 = 0; re5 = 0;
            cmp($sformatf("d5 pair%0d ovf", i), 32'(overflow5 | underflow5), 32'h0);
        end
        while (q5.size() != 0) begin
            cmp("d5 drain", 32'(rdata5), 32'(q5[0]));
            void'(q5.pop_front());
            re5 = 1;
            @(posedge pclk);
            #1;
            re5 = 0;
        end
        cmp("d5 empty", 32'(empty5), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
